// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Define ID_EX_FORWARD_EN to enable the EX/MEM and MEM/WB forwarding network.
module id_ex_operand_stage #(
  parameter int unsigned DW   = 32,
  parameter int unsigned RW   = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            btnc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [DW-1:0]   id_rs_data_i,
  input  logic [DW-1:0]   id_rt_data_i,
  input  logic [DW-1:0]   id_imm_i,
  input  logic [RW-1:0]   id_rs_i,
  input  logic [RW-1:0]   id_rt_i,
  input  logic [RW-1:0]   id_rd_i,
  input  logic            id_reg_dst_i,
  input  logic            id_alu_src_i,
  input  logic [1:0]      id_alu_op_i,
  input  logic [5:0]      id_funct_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic            id_mem_to_reg_i,
  input  logic            exmem_reg_write_i,
  input  logic [RW-1:0]   exmem_rd_i,
  input  logic [DW-1:0]   exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [RW-1:0]   memwb_rd_i,
  input  logic [DW-1:0]   memwb_result_i,
  output logic [DW-1:0]   alu1_o,
  output logic [DW-1:0]   alu2_o,
  output logic [3:0]      alu_control_o,
  output logic [DW-1:0]   ex_store_data_o,
  output logic [RW-1:0]   ex_dest_o,
  output logic            ex_valid_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_mem_to_reg_o,
  output logic            load_use_o,
  output logic [CNTW-1:0] bubble_cnt_o
);

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            alu_src_q, alu_src_d;
  logic [DW-1:0]   rs_data_q, rs_data_d;
  logic [DW-1:0]   rt_data_q, rt_data_d;
  logic [DW-1:0]   imm_q, imm_d;
  logic [RW-1:0]   rs_q, rs_d;
  logic [RW-1:0]   rt_q, rt_d;
  logic [RW-1:0]   dest_q, dest_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

  logic [3:0]      alu_ctrl_dec;
  logic [CNTW-1:0] bubble_cnt_inc;
  logic [DW-1:0]   rs_fwd, rt_fwd;

  // 1111 tells the ALU to hold its previous result for unknown functs.
  always_comb begin
    alu_ctrl_dec = 4'b1111;
    unique case (id_alu_op_i)
      2'b00: alu_ctrl_dec = 4'b0010;
      2'b01: alu_ctrl_dec = 4'b0110;
      2'b11: alu_ctrl_dec = 4'b0001;
      2'b10: begin
        case (id_funct_i)
          6'b100000: alu_ctrl_dec = 4'b0010;
          6'b100010: alu_ctrl_dec = 4'b0110;
          6'b100100: alu_ctrl_dec = 4'b0000;
          6'b100101: alu_ctrl_dec = 4'b0001;
          6'b101010: alu_ctrl_dec = 4'b0111;
          default:   alu_ctrl_dec = 4'b1111;
        endcase
      end
      default: alu_ctrl_dec = 4'b1111;
    endcase
  end

  assign bubble_cnt_inc = (bubble_cnt_q == {CNTW{1'b1}}) ? bubble_cnt_q
                                                         : bubble_cnt_q + CNTW'(1);

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    dest_d       = dest_q;
    alu_ctrl_d   = alu_ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i) begin
      // Bubble: only validity and control are killed, datapath fields hold.
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      bubble_cnt_d = bubble_cnt_inc;
    end else if (!stall_i) begin
      valid_d      = id_valid_i;
      reg_write_d  = id_valid_i & id_reg_write_i;
      mem_read_d   = id_valid_i & id_mem_read_i;
      mem_write_d  = id_valid_i & id_mem_write_i;
      mem_to_reg_d = id_valid_i & id_mem_to_reg_i;
      alu_src_d    = id_alu_src_i;
      rs_data_d    = id_rs_data_i;
      rt_data_d    = id_rt_data_i;
      imm_d        = id_imm_i;
      rs_d         = id_rs_i;
      rt_d         = id_rt_i;
      dest_d       = id_reg_dst_i ? id_rd_i : id_rt_i;
      alu_ctrl_d   = alu_ctrl_dec;
      if (!id_valid_i) bubble_cnt_d = bubble_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (btnc_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      alu_ctrl_q   <= 4'b0000;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      alu_ctrl_q   <= alu_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    rs_fwd = rs_data_q;
    rt_fwd = rt_data_q;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_q)) begin
      rs_fwd = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_q)) begin
      rs_fwd = memwb_result_i;
    end
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rt_q)) begin
      rt_fwd = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rt_q)) begin
      rt_fwd = memwb_result_i;
    end
  end

  assign load_use_o = valid_q & mem_read_q & (dest_q != '0) &
                      ((dest_q == id_rs_i) | (dest_q == id_rt_i));
`else
  assign rs_fwd = rs_data_q;
  assign rt_fwd = rt_data_q;

  // Without forwarding any in-flight writer to a source register is a hazard.
  assign load_use_o = valid_q & (mem_read_q | reg_write_q) & (dest_q != '0) &
                      ((dest_q == id_rs_i) | (dest_q == id_rt_i));

  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                        memwb_reg_write_i, memwb_rd_i, memwb_result_i, rs_q, rt_q};
`endif

  assign alu1_o          = rs_fwd;
  assign alu2_o          = alu_src_q ? imm_q : rt_fwd;
  assign ex_store_data_o = rt_fwd;
  assign alu_control_o   = alu_ctrl_q;
  assign ex_dest_o       = dest_q;
  assign ex_valid_o      = valid_q;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_mem_read_o   = mem_read_q;
  assign ex_mem_write_o  = mem_write_q;
  assign ex_mem_to_reg_o = mem_to_reg_q;
  assign bubble_cnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized bench for id_ex_operand_stage against an instruction-level reference model.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        btnc, stall, flush, id_valid;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs, rt, rd;
  logic        reg_dst, alu_src;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        wr, mr, mw, m2r;
  logic        xrw, wrw;
  logic [4:0]  xrd, wrd;
  logic [31:0] xres, wres;

  logic [31:0] alu1, alu2, store;
  logic [3:0]  ctrl;
  logic [4:0]  dest;
  logic        ev, erw, emr, emw, em2r, lu;
  logic [15:0] cnt;

  logic [31:0] s_alu1, s_alu2, s_store;
  logic [3:0]  s_ctrl;
  logic [4:0]  s_dest;
  logic        s_ev, s_erw, s_emr, s_emw, s_em2r, s_lu;
  logic [3:0]  cnt4;

  id_ex_operand_stage u_dut (
    .clk(clk), .btnc_i(btnc), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
    .id_rs_data_i(rs_data), .id_rt_data_i(rt_data), .id_imm_i(imm),
    .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd), .id_reg_dst_i(reg_dst),
    .id_alu_src_i(alu_src), .id_alu_op_i(alu_op), .id_funct_i(funct),
    .id_reg_write_i(wr), .id_mem_read_i(mr), .id_mem_write_i(mw), .id_mem_to_reg_i(m2r),
    .exmem_reg_write_i(xrw), .exmem_rd_i(xrd), .exmem_result_i(xres),
    .memwb_reg_write_i(wrw), .memwb_rd_i(wrd), .memwb_result_i(wres),
    .alu1_o(alu1), .alu2_o(alu2), .alu_control_o(ctrl), .ex_store_data_o(store),
    .ex_dest_o(dest), .ex_valid_o(ev), .ex_reg_write_o(erw), .ex_mem_read_o(emr),
    .ex_mem_write_o(emw), .ex_mem_to_reg_o(em2r), .load_use_o(lu), .bubble_cnt_o(cnt)
  );

  id_ex_operand_stage #(.CNTW(4)) u_dut4 (
    .clk(clk), .btnc_i(btnc), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
    .id_rs_data_i(rs_data), .id_rt_data_i(rt_data), .id_imm_i(imm),
    .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd), .id_reg_dst_i(reg_dst),
    .id_alu_src_i(alu_src), .id_alu_op_i(alu_op), .id_funct_i(funct),
    .id_reg_write_i(wr), .id_mem_read_i(mr), .id_mem_write_i(mw), .id_mem_to_reg_i(m2r),
    .exmem_reg_write_i(xrw), .exmem_rd_i(xrd), .exmem_result_i(xres),
    .memwb_reg_write_i(wrw), .memwb_rd_i(wrd), .memwb_result_i(wres),
    .alu1_o(s_alu1), .alu2_o(s_alu2), .alu_control_o(s_ctrl), .ex_store_data_o(s_store),
    .ex_dest_o(s_dest), .ex_valid_o(s_ev), .ex_reg_write_o(s_erw), .ex_mem_read_o(s_emr),
    .ex_mem_write_o(s_emw), .ex_mem_to_reg_o(s_em2r), .load_use_o(s_lu), .bubble_cnt_o(cnt4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model of the instruction sitting in EX.
  bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_alu_src, m_known;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt, m_dest;
  logic [3:0]  m_ctrl;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd1;
    if (f == 6'd32) return 4'd2;
    if (f == 6'd34) return 4'd6;
    if (f == 6'd36) return 4'd0;
    if (f == 6'd37) return 4'd1;
    if (f == 6'd42) return 4'd7;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] regval);
`ifdef ID_EX_FORWARD_EN
    if (idx != 0 && xrw && xrd == idx) return xres;
    if (idx != 0 && wrw && wrd == idx) return wres;
`endif
    return regval;
  endfunction

  function automatic bit ref_load_use();
    bit writer;
`ifdef ID_EX_FORWARD_EN
    writer = m_mr;
`else
    writer = m_mr || m_rw;
`endif
    return m_valid && writer && m_dest != 0 && (m_dest == rs || m_dest == rt);
  endfunction

  task automatic check_all();
    check_eq("ex_valid", {31'd0, ev}, {31'd0, m_valid});
    check_eq("reg_write", {31'd0, erw}, {31'd0, m_rw});
    check_eq("mem_read", {31'd0, emr}, {31'd0, m_mr});
    check_eq("mem_write", {31'd0, emw}, {31'd0, m_mw});
    check_eq("mem_to_reg", {31'd0, em2r}, {31'd0, m_m2r});
    check_eq("load_use", {31'd0, lu}, {31'd0, ref_load_use()});
    check_eq("bubble_cnt", {16'd0, cnt}, m_cnt);
    check_eq("bubble_cnt4", {28'd0, cnt4}, (m_cnt > 15) ? 15 : m_cnt);
    if (m_known) begin
      check_eq("alu1", alu1, ref_fwd(m_rs, m_rs_data));
      check_eq("alu2", alu2, m_alu_src ? m_imm : ref_fwd(m_rt, m_rt_data));
      check_eq("store", store, ref_fwd(m_rt, m_rt_data));
      check_eq("alu_ctrl", {28'd0, ctrl}, {28'd0, m_ctrl});
      check_eq("dest", {27'd0, dest}, {27'd0, m_dest});
    end
  endtask

  task automatic model_update();
    if (btnc) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_alu_src} = '0;
      m_rs_data = 0; m_rt_data = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_dest = 0; m_ctrl = 0; m_cnt = 0; m_known = 1;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r} = '0;
      if (m_cnt < 65535) m_cnt++;
      m_known = 0;
    end else if (!stall) begin
      m_valid = id_valid;
      m_rw = id_valid && wr; m_mr = id_valid && mr;
      m_mw = id_valid && mw; m_m2r = id_valid && m2r;
      m_alu_src = alu_src; m_rs_data = rs_data; m_rt_data = rt_data; m_imm = imm;
      m_rs = rs; m_rt = rt; m_dest = reg_dst ? rd : rt;
      m_ctrl = ref_ctrl(alu_op, funct);
      if (!id_valid && m_cnt < 65535) m_cnt++;
      m_known = 1;
    end
  endtask

  // Entered just after a falling edge with inputs applied.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    logic [5:0] functs [6];
    functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    btnc = ($urandom_range(0, 49) == 0);
    flush = ($urandom_range(0, 9) == 0);
    stall = ($urandom_range(0, 4) == 0);
    id_valid = ($urandom_range(0, 5) != 0);
    rs_data = $urandom; rt_data = $urandom; imm = $urandom;
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
    reg_dst = 1'($urandom); alu_src = 1'($urandom); alu_op = 2'($urandom);
    funct = functs[$urandom_range(0, 5)];
    if ($urandom_range(0, 5) == 0) funct = 6'($urandom);
    wr = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom); m2r = 1'($urandom);
    xrw = 1'($urandom); xrd = 5'($urandom_range(0, 3)); xres = $urandom;
    wrw = 1'($urandom); wrd = 5'($urandom_range(0, 3)); wres = $urandom;
  endtask

  task automatic capture(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic [31:0] da, input logic [31:0] db);
    btnc = 0; stall = 0; flush = 0; id_valid = 1;
    rs = a; rt = b; rd = d; rs_data = da; rt_data = db;
  endtask

  initial begin
    {btnc, stall, flush, id_valid, reg_dst, alu_src, wr, mr, mw, m2r, xrw, wrw} = '0;
    {rs_data, rt_data, imm, xres, wres} = '0;
    {rs, rt, rd, xrd, wrd} = '0;
    alu_op = 0; funct = 0;
    @(negedge clk);

    // Reset dominates a stall with a live instruction presented.
    btnc = 1; stall = 1; id_valid = 1; wr = 1; mr = 1; alu_op = 2'd2; funct = 6'd42;
    rs = 5'd1; rt = 5'd2; rs_data = 32'h55; rt_data = 32'h66;
    @(posedge clk); model_update(); @(negedge clk);
    btnc = 0; rs = 0; rt = 0;
    #1;
    check_eq("rst_valid", {31'd0, ev}, 0);
    check_eq("rst_ctrl", {28'd0, ctrl}, 0);
    check_eq("rst_cnt", {16'd0, cnt}, 0);
    check_eq("rst_alu1", alu1, 0);
    cycle();

    // R-type slt with rd destination.
    capture(5'd1, 5'd2, 5'd7, 32'd5, 32'd9);
    alu_op = 2'd2; funct = 6'b101010; reg_dst = 1; alu_src = 0; wr = 1; mr = 0;
    cycle();
    stall = 1; #1;
    check_eq("rtype_alu1", alu1, 32'd5);
    check_eq("rtype_alu2", alu2, 32'd9);
    check_eq("rtype_ctrl", {28'd0, ctrl}, 32'd7);
    check_eq("rtype_dest", {27'd0, dest}, 32'd7);
    cycle();

    // Forwarding priority on rs = 3.
    capture(5'd3, 5'd4, 5'd5, 32'h11, 32'h22);
    cycle();
    stall = 1; xrw = 1; xrd = 5'd3; xres = 32'hAAAA0000; wrw = 1; wrd = 5'd3; wres = 32'h5555;
    #1;
`ifdef ID_EX_FORWARD_EN
    check_eq("fwd_exmem", alu1, 32'hAAAA0000);
`else
    check_eq("fwd_exmem", alu1, 32'h11);
`endif
    cycle();
    xrw = 0; #1;
`ifdef ID_EX_FORWARD_EN
    check_eq("fwd_memwb", alu1, 32'h5555);
`else
    check_eq("fwd_memwb", alu1, 32'h11);
`endif
    cycle();
    capture(5'd0, 5'd4, 5'd5, 32'h33, 32'h44);
    cycle();
    stall = 1; xrw = 1; xrd = 0; wrw = 1; wrd = 0; #1;
    check_eq("fwd_r0", alu1, 32'h33);
    cycle();
    xrw = 0; wrw = 0;

    // Three stalls then stall together with flush.
    repeat (3) cycle();
    flush = 1; cycle();
    flush = 0; #1;
    check_eq("sf_valid", {31'd0, ev}, 0);
    check_eq("sf_cnt", {16'd0, cnt}, 1);
    cycle();

    // Load to $8 in EX with the next instruction reading $8.
    capture(5'd9, 5'd8, 5'd0, 32'd1, 32'd2);
    reg_dst = 0; mr = 1; wr = 1; alu_src = 1; alu_op = 0;
    cycle();
    stall = 1; rs = 5'd8; rt = 5'd3; #1;
    check_eq("lu_hit", {31'd0, lu}, 1);
    cycle();
    capture(5'd0, 5'd0, 5'd0, 32'd1, 32'd2);
    cycle();
    stall = 1; #1;
    check_eq("lu_r0", {31'd0, lu}, 0);
    cycle();

    // Saturation of the narrow counter.
    stall = 0; flush = 1;
    repeat (20) cycle();
    flush = 0; stall = 1; #1;
    check_eq("sat_cnt4", {28'd0, cnt4}, 15);
    cycle();

    repeat (1500) begin
      randomize_inputs();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
